rr_mux_arbiter_4: RTL



---
 rtl/rr_mux_arbiter_4_pkg.sv | 31 +++
 rtl/rr_mux_arbiter_4_if.sv | 26 ++
 rtl/rr_mux_arbiter_4_mux.sv | 16 +
 rtl/rr_mux_arbiter_4.sv | 91 +++++++++
 4 files changed

// File: rtl/rr_mux_arbiter_4_pkg.sv
// Shared types and helpers for the four-requester round-robin mux arbiter.
package rr_arb_pkg;

  localparam int unsigned NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First set bit of valid in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic pick_t rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    pick_t      p;
    logic [1:0] c;
    p = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      c = ptr + 2'(k);
      if (!p.found && valid[c]) begin
        p.found = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_4_if.sv
// Requester/sink bundle of the round-robin mux arbiter.
interface rr_mux_arbiter_4_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]          req_valid;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_ready;
  logic [1:0]          sel;
  logic                busy;
  logic                timeout_pulse;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, sel, busy, timeout_pulse
  );

  // Requesters and sink side.
  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, sel, busy, timeout_pulse
  );
endinterface

// File: rtl/rr_mux_arbiter_4_mux.sv
// DATA_W-bit 4:1 mux built as one 2-level select per bit.
module mux_4_1_bus #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);
  for (genvar b = 0; b < W; b++) begin : g_bit
    assign y[b] = sel[1] ? (sel[0] ? d3[b] : d2[b])
                         : (sel[0] ? d1[b] : d0[b]);
  end
endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter over four valid/data requesters feeding a single registered output lane.
module rr_mux_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_mux_arbiter_4_if.master   bus
);

  localparam int unsigned CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  state_t            state, state_next;
  logic [1:0]        ptr;
  logic [1:0]        sel_q;
  logic [DATA_W-1:0] data_q;
  logic [CW-1:0]     stall_q;
  logic              tp_q;

  pick_t             pick;
  logic [DATA_W-1:0] mux_y;
  logic              grant_now;
  logic              accept;
  logic              expire;

  assign pick      = rr_pick(bus.req_valid, ptr);
  assign grant_now = (state == IDLE) && pick.found;
  assign accept    = (state == GRANT) && bus.out_ready;
  // Expiry fires on the HOLD_MAX-th stalled cycle, so the pulse lands on the next one.
  assign expire    = (HOLD_MAX != 0) && (state == GRANT) && !bus.out_ready &&
                     ((32'(stall_q) + 32'd1) >= HOLD_MAX);

  mux_4_1_bus #(.W(DATA_W)) u_mux (
    .d0  (bus.req_data[0*DATA_W +: DATA_W]),
    .d1  (bus.req_data[1*DATA_W +: DATA_W]),
    .d2  (bus.req_data[2*DATA_W +: DATA_W]),
    .d3  (bus.req_data[3*DATA_W +: DATA_W]),
    .sel (pick.idx),
    .y   (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (pick.found)       state_next = GRANT;
      GRANT: if (accept || expire) state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      stall_q <= '0;
      tp_q    <= 1'b0;
    end else begin
      tp_q <= expire;
      if (grant_now) begin
        sel_q   <= pick.idx;
        data_q  <= mux_y;
        stall_q <= '0;
      end else if (state == GRANT) begin
        if (accept || expire) begin
          ptr <= sel_q + 2'd1;
        end else if (stall_q != '1) begin
          stall_q <= stall_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.out_valid     = (state == GRANT);
    bus.busy          = (state == GRANT);
    bus.sel           = sel_q;
    bus.out_data      = data_q;
    bus.timeout_pulse = tp_q;
    bus.req_ready     = '0;
    if (accept) bus.req_ready[sel_q] = 1'b1;
  end

endmodule
